// File: rtl/axis_pkg.sv
// Shared AXI-stream helpers: collector state encoding and the default float word width.
package axis_pkg;

    localparam int SIZE_DEFAULT = 64;

    typedef enum logic [2:0] {
        COL_A,
        COL_B,
        COL_C,
        COL_FULL,
        COL_SYNC
    } col_state_t;

endpackage

// File: rtl/axis_fork3.sv
// Fans a loaded (a, b, c) triple out to three independent AXI-stream masters; each valid holds until its own handshake.
// Load lands at the next edge; load_ok and all_done reflect this cycle's handshakes, so reload needs no bubble.
module axis_fork3 #(
    parameter int SIZE = 64
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [SIZE-1:0] a_word,
    input  logic [SIZE-1:0] b_word,
    input  logic [SIZE-1:0] c_word,
    input  logic            load,
    output logic [SIZE-1:0] m_axis_a_tdata,
    output logic [SIZE-1:0] m_axis_b_tdata,
    output logic [SIZE-1:0] m_axis_c_tdata,
    output logic            m_axis_a_tvalid,
    output logic            m_axis_b_tvalid,
    output logic            m_axis_c_tvalid,
    input  logic            m_axis_a_tready,
    input  logic            m_axis_b_tready,
    input  logic            m_axis_c_tready,
    output logic            load_ok,
    output logic            all_done
);

    logic [2:0] pend;
    logic [2:0] hs;
    logic [2:0] pend_left;
    logic       do_load;

    // pend_left is what would still be outstanding after this edge's handshakes
    assign hs        = pend & {m_axis_c_tready, m_axis_b_tready, m_axis_a_tready};
    assign pend_left = pend & ~hs;
    assign load_ok   = (pend_left == 3'b000);
    assign all_done  = (pend != 3'b000) && (pend_left == 3'b000);
    assign do_load   = load && load_ok;

    assign m_axis_a_tvalid = pend[0];
    assign m_axis_b_tvalid = pend[1];
    assign m_axis_c_tvalid = pend[2];

    always_ff @(posedge aclk) begin
        if (areset) begin
            pend <= 3'b000;
        end else if (do_load) begin
            pend <= 3'b111;
        end else begin
            pend <= pend_left;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_load) begin
            m_axis_a_tdata <= a_word;
            m_axis_b_tdata <= b_word;
            m_axis_c_tdata <= c_word;
        end
    end

endmodule

// File: rtl/quadratic_coeff_issuer.sv
// Collects serial (a, b, c) words framed by tlast and issues each triple on three AXI-stream masters.
// Triple issued the cycle after c is accepted when issue is idle; s_axis_tready drops only while a full triple waits.
module quadratic_coeff_issuer
    import axis_pkg::*;
#(
    parameter int SIZE  = SIZE_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [SIZE-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [SIZE-1:0]  m_axis_a_tdata,
    output logic [SIZE-1:0]  m_axis_b_tdata,
    output logic [SIZE-1:0]  m_axis_c_tdata,
    output logic             m_axis_a_tvalid,
    output logic             m_axis_b_tvalid,
    output logic             m_axis_c_tvalid,
    input  logic             m_axis_a_tready,
    input  logic             m_axis_b_tready,
    input  logic             m_axis_c_tready,
    output logic [CNT_W-1:0] triple_count,
    output logic             frame_err
);

    col_state_t      state;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    logic [SIZE-1:0] c_reg;
    logic            accept;
    logic            load;
    logic            load_ok;
    logic            all_done;

    assign s_axis_tready = (state != COL_FULL);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign load          = (state == COL_FULL) && load_ok;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= COL_A;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COL_A, COL_B: begin
                    if (accept) begin
                        if (s_axis_tlast) begin
                            frame_err <= 1'b1;
                            state     <= COL_A;
                        end else begin
                            state <= (state == COL_A) ? COL_B : COL_C;
                        end
                    end
                end
                COL_C: begin
                    if (accept) begin
                        if (s_axis_tlast) begin
                            state <= COL_FULL;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= COL_SYNC;
                        end
                    end
                end
                COL_FULL: begin
                    if (load_ok) state <= COL_A;
                end
                COL_SYNC: begin
                    // drop silently until the frame boundary comes round
                    if (accept && s_axis_tlast) state <= COL_A;
                end
                default: state <= COL_A;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            case (state)
                COL_A:   a_reg <= s_axis_tdata;
                COL_B:   b_reg <= s_axis_tdata;
                COL_C:   c_reg <= s_axis_tdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            triple_count <= '0;
        end else if (all_done) begin
            triple_count <= triple_count + 1'b1;
        end
    end

    axis_fork3 #(
        .SIZE(SIZE)
    ) u_fork (
        .aclk            (aclk),
        .areset          (areset),
        .a_word          (a_reg),
        .b_word          (b_reg),
        .c_word          (c_reg),
        .load            (load),
        .m_axis_a_tdata  (m_axis_a_tdata),
        .m_axis_b_tdata  (m_axis_b_tdata),
        .m_axis_c_tdata  (m_axis_c_tdata),
        .m_axis_a_tvalid (m_axis_a_tvalid),
        .m_axis_b_tvalid (m_axis_b_tvalid),
        .m_axis_c_tvalid (m_axis_c_tvalid),
        .m_axis_a_tready (m_axis_a_tready),
        .m_axis_b_tready (m_axis_b_tready),
        .m_axis_c_tready (m_axis_c_tready),
        .load_ok         (load_ok),
        .all_done        (all_done)
    );

endmodule

// File: tb/tb_quadratic_coeff_issuer.sv
// Bench for quadratic_coeff_issuer: directed scenarios plus randomized framing/readys against a list-based framing model.
module tb_quadratic_coeff_issuer;

    localparam int SIZE   = 64;
    localparam int CNT_W  = 32;
    localparam int PERIOD = 10;

    logic             aclk = 1'b0;
    logic             areset;
    logic [SIZE-1:0]  s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [SIZE-1:0]  m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata;
    logic             m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid;
    logic             m_axis_a_tready, m_axis_b_tready, m_axis_c_tready;
    logic [CNT_W-1:0] triple_count;
    logic             frame_err;

    int vectors = 0;
    int errors  = 0;
    bit rdy_rand = 0;

    logic [64:0]  acc[$];
    logic [63:0]  obs_a[$], obs_b[$], obs_c[$];
    int           obs_ferr;
    logic [191:0] exp_t[$];
    int           exp_ferr;

    quadratic_coeff_issuer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_a_tdata  (m_axis_a_tdata),
        .m_axis_b_tdata  (m_axis_b_tdata),
        .m_axis_c_tdata  (m_axis_c_tdata),
        .m_axis_a_tvalid (m_axis_a_tvalid),
        .m_axis_b_tvalid (m_axis_b_tvalid),
        .m_axis_c_tvalid (m_axis_c_tvalid),
        .m_axis_a_tready (m_axis_a_tready),
        .m_axis_b_tready (m_axis_b_tready),
        .m_axis_c_tready (m_axis_c_tready),
        .triple_count    (triple_count),
        .frame_err       (frame_err)
    );

    always #(PERIOD/2) aclk = ~aclk;

    // Monitor on the falling edge: values here are the ones the next rising edge will see.
    initial begin
        obs_ferr = 0;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (s_axis_tvalid && s_axis_tready) acc.push_back({s_axis_tlast, s_axis_tdata});
                if (m_axis_a_tvalid && m_axis_a_tready) obs_a.push_back(m_axis_a_tdata);
                if (m_axis_b_tvalid && m_axis_b_tready) obs_b.push_back(m_axis_b_tdata);
                if (m_axis_c_tvalid && m_axis_c_tready) obs_c.push_back(m_axis_c_tdata);
            end
            if (frame_err) obs_ferr++;
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_rand) {m_axis_c_tready, m_axis_b_tready, m_axis_a_tready} = 3'($urandom_range(0, 7));
        end
    end

    initial begin
        #(PERIOD * 10000);
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    // Framing model: partial words are a list, resync is a flag; triples are what survive.
    task automatic build_model();
        logic [63:0] part[$];
        bit          sync;
        logic [64:0] w;
        exp_t.delete();
        exp_ferr = 0;
        sync     = 0;
        foreach (acc[i]) begin
            w = acc[i];
            if (sync) begin
                if (w[64]) sync = 0;
            end else begin
                part.push_back(w[63:0]);
                if (part.size() < 3) begin
                    if (w[64]) begin
                        exp_ferr++;
                        part.delete();
                    end
                end else begin
                    if (w[64]) exp_t.push_back({part[0], part[1], part[2]});
                    else begin
                        exp_ferr++;
                        sync = 1;
                    end
                    part.delete();
                end
            end
        end
    endtask

    task automatic clear_obs();
        acc.delete();
        obs_a.delete();
        obs_b.delete();
        obs_c.delete();
        obs_ferr = 0;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_rdy(input logic [2:0] r);
        {m_axis_c_tready, m_axis_b_tready, m_axis_a_tready} = r;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        bit done;
        done          = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge aclk);
            done = s_axis_tready;
            tick();
        end
        s_axis_tvalid = 1'b0;
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL send_word: tready got 0 for 1000 cycles, need 1");
        end
    endtask

    task automatic send_triple(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        send_word(a, 1'b0);
        send_word(b, 1'b0);
        send_word(c, 1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (k < 300 && (m_axis_a_tvalid || m_axis_b_tvalid || m_axis_c_tvalid || !s_axis_tready)) begin
            tick();
            k++;
        end
        vectors++;
        if (k >= 300) begin
            errors++;
            $display("FAIL %s drain: outputs still busy after %0d cycles, need idle", name, k);
        end
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        tick();
        tick();
        areset = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        set_rdy(3'b111);
        do_reset();
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b need 000", {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
        end
        vectors++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b need 1", s_axis_tready);
        end
        vectors++;
        if (triple_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d need 0", triple_count);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_err: got %b need 0", frame_err);
        end
    endtask

    task automatic test_basic();
        set_rdy(3'b111);
        send_triple(64'h3FF0000000000000, 64'hC008000000000000, 64'h4000000000000000);
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL basic_early_valid: got %b need 000", {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
        end
        tick();
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b111) begin
            errors++;
            $display("FAIL basic_valid: got %b need 111", {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
        end
        vectors++;
        if ({m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata} !==
            {64'h3FF0000000000000, 64'hC008000000000000, 64'h4000000000000000}) begin
            errors++;
            $display("FAIL basic_data: got %h %h %h need 3ff0000000000000 c008000000000000 4000000000000000",
                     m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata);
        end
        tick();
        vectors++;
        if (triple_count !== 32'd1) begin
            errors++;
            $display("FAIL basic_count: got %0d need 1", triple_count);
        end
    endtask

    task automatic test_b_stall();
        logic [63:0]      a1, b1, c1, a2, b2, c2;
        logic [CNT_W-1:0] base;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom}; c2 = {$urandom, $urandom};
        clear_obs();
        set_rdy(3'b101);
        base = triple_count;
        send_triple(a1, b1, c1);
        tick();
        send_triple(a2, b2, c2);
        for (int r = 0; r < 2; r++) begin
            vectors++;
            if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b010) begin
                errors++;
                $display("FAIL stall_valids[%0d]: got %b need 010", r, {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
            end
            vectors++;
            if (m_axis_b_tdata !== b1) begin
                errors++;
                $display("FAIL stall_b_data[%0d]: got %h need %h", r, m_axis_b_tdata, b1);
            end
            vectors++;
            if (s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL stall_tready[%0d]: got %b need 0", r, s_axis_tready);
            end
            vectors++;
            if (triple_count !== base) begin
                errors++;
                $display("FAIL stall_count[%0d]: got %0d need %0d", r, triple_count, base);
            end
            repeat (6) tick();
        end
        set_rdy(3'b111);
        tick();
        vectors++;
        if (triple_count !== base + 1) begin
            errors++;
            $display("FAIL stall_release_count: got %0d need %0d", triple_count, base + 1);
        end
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid, m_axis_a_tdata} !== {3'b111, a2}) begin
            errors++;
            $display("FAIL stall_reload: got %b %h need 111 %h",
                     {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid}, m_axis_a_tdata, a2);
        end
        drain("b_stall");
        build_model();
        vectors++;
        if (obs_b.size() != 2 || obs_b[0] !== b1 || obs_b[1] !== b2 || obs_a.size() != 2 || obs_c.size() != 2) begin
            errors++;
            $display("FAIL stall_order: got %0d/%0d/%0d words, need 2/2/2 in order", obs_a.size(), obs_b.size(), obs_c.size());
        end
    endtask

    task automatic test_stream();
        logic [CNT_W-1:0] base;
        time              t0, t1;
        clear_obs();
        set_rdy(3'b111);
        base = triple_count;
        t0 = $time;
        for (int n = 0; n < 100; n++) send_triple({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        t1 = $time;
        // three accepted words plus one full-cycle stall per triple, minus the last triple's stall
        vectors++;
        if ((t1 - t0) / PERIOD != 64'd399) begin
            errors++;
            $display("FAIL stream_cycles: got %0d need 399", (t1 - t0) / PERIOD);
        end
        drain("stream");
        vectors++;
        if (triple_count - base !== 32'd100) begin
            errors++;
            $display("FAIL stream_count: got %0d need 100", triple_count - base);
        end
        build_model();
        vectors++;
        if (obs_a.size() != exp_t.size() || obs_b.size() != exp_t.size() || obs_c.size() != exp_t.size()) begin
            errors++;
            $display("FAIL stream_size: got %0d/%0d/%0d need %0d", obs_a.size(), obs_b.size(), obs_c.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < obs_a.size() && i < obs_b.size() && i < obs_c.size(); i++) begin
            vectors++;
            if ({obs_a[i], obs_b[i], obs_c[i]} !== exp_t[i]) begin
                errors++;
                $display("FAIL stream_triple[%0d]: got %h need %h", i, {obs_a[i], obs_b[i], obs_c[i]}, exp_t[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        logic [63:0] a, b, c;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        clear_obs();
        set_rdy(3'b111);
        send_word({$urandom, $urandom}, 1'b0);
        send_word({$urandom, $urandom}, 1'b1);
        vectors++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_ferr_pulse: got %b need 1", frame_err);
        end
        tick();
        vectors++;
        if (frame_err !== 1'b0 || {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL short_after: got ferr=%b valids=%b need ferr=0 valids=000",
                     frame_err, {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
        end
        send_triple(a, b, c);
        drain("short_frame");
        build_model();
        vectors++;
        if (obs_ferr != exp_ferr || exp_ferr != 1) begin
            errors++;
            $display("FAIL short_ferr_count: got %0d need %0d", obs_ferr, exp_ferr);
        end
        vectors++;
        if (obs_a.size() != 1 || obs_b.size() != 1 || obs_c.size() != 1 || {obs_a[0], obs_b[0], obs_c[0]} !== {a, b, c}) begin
            errors++;
            $display("FAIL short_issue: got %0d triples need 1 equal to %h", obs_a.size(), {a, b, c});
        end
    endtask

    task automatic test_sync();
        clear_obs();
        set_rdy(3'b111);
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0);
        send_word({$urandom, $urandom}, 1'b0);
        send_word({$urandom, $urandom}, 1'b1);
        send_triple({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        drain("sync");
        build_model();
        vectors++;
        if (obs_ferr != exp_ferr || obs_ferr != 1) begin
            errors++;
            $display("FAIL sync_ferr_count: got %0d need 1", obs_ferr);
        end
        vectors++;
        if (obs_a.size() != 1 || obs_b.size() != 1 || obs_c.size() != 1 || exp_t.size() != 1) begin
            errors++;
            $display("FAIL sync_issue_count: got %0d need 1", obs_a.size());
        end else begin
            vectors++;
            if ({obs_a[0], obs_b[0], obs_c[0]} !== exp_t[0]) begin
                errors++;
                $display("FAIL sync_triple: got %h need %h", {obs_a[0], obs_b[0], obs_c[0]}, exp_t[0]);
            end
        end
    endtask

    task automatic test_random();
        int kind, len;
        clear_obs();
        rdy_rand = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) len = $urandom_range(1, 2);
            else if (kind == 1) len = $urandom_range(4, 6);
            else len = 3;
            for (int w = 0; w < len; w++) send_word({$urandom, $urandom}, (w == len - 1));
            repeat ($urandom_range(0, 2)) tick();
        end
        rdy_rand = 0;
        tick();
        set_rdy(3'b111);
        drain("random");
        build_model();
        vectors++;
        if (obs_ferr != exp_ferr) begin
            errors++;
            $display("FAIL random_ferr_count: got %0d need %0d", obs_ferr, exp_ferr);
        end
        vectors++;
        if (obs_a.size() != exp_t.size() || obs_b.size() != exp_t.size() || obs_c.size() != exp_t.size()) begin
            errors++;
            $display("FAIL random_size: got %0d/%0d/%0d need %0d", obs_a.size(), obs_b.size(), obs_c.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < obs_a.size() && i < obs_b.size() && i < obs_c.size(); i++) begin
            vectors++;
            if ({obs_a[i], obs_b[i], obs_c[i]} !== exp_t[i]) begin
                errors++;
                $display("FAIL random_triple[%0d]: got %h need %h", i, {obs_a[i], obs_b[i], obs_c[i]}, exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        set_rdy(3'b010);
        send_triple({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        tick();
        send_word({$urandom, $urandom}, 1'b0);
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid} !== 3'b101) begin
            errors++;
            $display("FAIL midreset_setup: got %b need 101", {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid});
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        vectors++;
        if ({m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid, s_axis_tready, frame_err} !== 5'b00010) begin
            errors++;
            $display("FAIL midreset_flags: got valids=%b tready=%b ferr=%b need 000 1 0",
                     {m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid}, s_axis_tready, frame_err);
        end
        vectors++;
        if (triple_count !== '0) begin
            errors++;
            $display("FAIL midreset_count: got %0d need 0", triple_count);
        end
        tick();
        vectors++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ferr_late: got %b need 0", frame_err);
        end
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        set_rdy(3'b111);
        test_reset();
        test_basic();
        test_b_stall();
        test_stream();
        test_short_frame();
        test_sync();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
